// File: rtl/phy_dq_lane_ctrl.sv
// DQ lane controller on the CLKDIV side: bus direction with turnaround guards,
// per-lane bitslip read training, and registered rx/tx word paths.
module phy_dq_lane_ctrl #(
  parameter int unsigned LANES         = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter logic [7:0]  TRAIN_PATTERN = 8'h1D,
  parameter int unsigned SLIP_WAIT     = 3,
  parameter int unsigned MATCH_COUNT   = 4,
  parameter int unsigned TURN_CYCLES   = 2
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          train_start,
  output logic                          train_busy,
  output logic                          train_done,
  output logic                          train_fail,
  output logic [LANES-1:0]              lane_locked,
  output logic [LANES-1:0]              bitslip,
  input  logic [LANES*DATA_WIDTH-1:0]   rx_data_in,
  input  logic                          rx_en,
  output logic [LANES*DATA_WIDTH-1:0]   rx_data_out,
  output logic                          rx_valid,
  input  logic                          tx_en,
  input  logic [LANES*DATA_WIDTH-1:0]   tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [LANES*DATA_WIDTH-1:0]   tx_data_out,
  output logic [LANES-1:0]              tri_t
);

  localparam int unsigned W      = LANES * DATA_WIDTH;
  localparam int unsigned WaitW  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int unsigned SlipW  = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [WaitW-1:0]      WaitLast  = WaitW'(SLIP_WAIT - 1);
  localparam logic [SlipW-1:0]      SlipMax   = SlipW'(2 * DATA_WIDTH);
  localparam logic [3:0]            MatchLast = 4'(MATCH_COUNT - 1);
  localparam logic [3:0]            TurnLast  = 4'(TURN_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] Pattern   = TRAIN_PATTERN[DATA_WIDTH-1:0];

  typedef enum logic [1:0] {StRx, StTurnTx, StTx, StTurnRx} dir_st_e;
  typedef enum logic [1:0] {LnWait, LnCheck, LnLocked, LnFailed} lane_st_e;

  dir_st_e          dir_q, dir_d;
  logic [3:0]       turn_q, turn_d;
  logic             busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic             rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic [W-1:0]     rx_data_q, rx_data_d, tx_out_q, tx_out_d;
  logic [LANES-1:0] tri_q, tri_d, locked_q, locked_d, slip_q, slip_d, term_d;

  lane_st_e         lane_st_q [LANES];
  lane_st_e         lane_st_d [LANES];
  logic [WaitW-1:0] wait_q    [LANES];
  logic [WaitW-1:0] wait_d    [LANES];
  logic [3:0]       match_q   [LANES];
  logic [3:0]       match_d   [LANES];
  logic [SlipW-1:0] slips_q   [LANES];
  logic [SlipW-1:0] slips_d   [LANES];

  logic start_acc, rx_fire;

  // A start request in RX wins over a simultaneous tx_en.
  assign start_acc = train_start && (dir_q == StRx) && !busy_q;
  assign rx_fire   = (dir_q == StRx) && rx_en && !busy_q;

  always_comb begin
    dir_d  = dir_q;
    turn_d = turn_q;
    unique case (dir_q)
      StRx: begin
        if (tx_en && !busy_q && !train_start) begin
          dir_d  = StTurnTx;
          turn_d = '0;
        end
      end
      StTurnTx: begin
        if (turn_q == TurnLast) dir_d = StTx;
        else                    turn_d = turn_q + 1'b1;
      end
      StTx: begin
        if (!tx_en) begin
          dir_d  = StTurnRx;
          turn_d = '0;
        end
      end
      StTurnRx: begin
        if (turn_q == TurnLast) dir_d = StRx;
        else                    turn_d = turn_q + 1'b1;
      end
    endcase

    tri_d      = ((dir_d == StRx) || (dir_d == StTurnRx)) ? {LANES{1'b1}} : '0;
    tx_ready_d = (dir_d == StTx);
    tx_out_d   = (tx_valid && tx_ready_q) ? tx_data : '0;
    rx_valid_d = rx_fire;
    rx_data_d  = rx_fire ? rx_data_in : rx_data_q;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_st_d[i] = lane_st_q[i];
      wait_d[i]    = wait_q[i];
      match_d[i]   = match_q[i];
      slips_d[i]   = slips_q[i];
      slip_d[i]    = 1'b0;
      if (start_acc) begin
        lane_st_d[i] = LnWait;
        wait_d[i]    = '0;
        match_d[i]   = '0;
        slips_d[i]   = '0;
      end else if (busy_q) begin
        unique case (lane_st_q[i])
          LnWait: begin
            if (wait_q[i] == WaitLast) begin
              lane_st_d[i] = LnCheck;
              wait_d[i]    = '0;
            end else begin
              wait_d[i] = wait_q[i] + 1'b1;
            end
          end
          LnCheck: begin
            if (rx_data_in[i*DATA_WIDTH +: DATA_WIDTH] == Pattern) begin
              match_d[i] = match_q[i] + 1'b1;
              if (match_q[i] == MatchLast) lane_st_d[i] = LnLocked;
            end else begin
              match_d[i] = '0;
              if (slips_q[i] == SlipMax) begin
                lane_st_d[i] = LnFailed;
              end else begin
                slip_d[i]    = 1'b1;
                slips_d[i]   = slips_q[i] + 1'b1;
                lane_st_d[i] = LnWait;
              end
            end
          end
          LnLocked, LnFailed: ;
        endcase
      end
      locked_d[i] = (lane_st_d[i] == LnLocked);
      term_d[i]   = (lane_st_d[i] == LnLocked) || (lane_st_d[i] == LnFailed);
    end

    // Flags follow the lanes' next state so done/fail line up with lane_locked.
    busy_d = busy_q;
    done_d = done_q;
    fail_d = fail_q;
    if (start_acc) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      fail_d = 1'b0;
    end else if (busy_q && (&term_d)) begin
      busy_d = 1'b0;
      done_d = &locked_d;
      fail_d = ~(&locked_d);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      dir_q      <= StRx;
      turn_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      tx_out_q   <= '0;
      tri_q      <= {LANES{1'b1}};
      locked_q   <= '0;
      slip_q     <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_st_q[i] <= LnWait;
        wait_q[i]    <= '0;
        match_q[i]   <= '0;
        slips_q[i]   <= '0;
      end
    end else begin
      dir_q      <= dir_d;
      turn_q     <= turn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      tx_out_q   <= tx_out_d;
      tri_q      <= tri_d;
      locked_q   <= locked_d;
      slip_q     <= slip_d;
      for (int i = 0; i < LANES; i++) begin
        lane_st_q[i] <= lane_st_d[i];
        wait_q[i]    <= wait_d[i];
        match_q[i]   <= match_d[i];
        slips_q[i]   <= slips_d[i];
      end
    end
  end

  assign train_busy  = busy_q;
  assign train_done  = done_q;
  assign train_fail  = fail_q;
  assign lane_locked = locked_q;
  assign bitslip     = slip_q;
  assign rx_data_out = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ready    = tx_ready_q;
  assign tx_data_out = tx_out_q;
  assign tri_t       = tri_q;

endmodule

// File: tb/tb_phy_dq_lane_ctrl.sv
// Directed bench for phy_dq_lane_ctrl: reset, rx path, training (aligned,
// rotated, failing lane), turnaround timing, conflicts and reset during TX.
module tb_phy_dq_lane_ctrl;

  logic        clk_in, reset, train_start, train_busy, train_done, train_fail;
  logic [7:0]  lane_locked, bitslip, tri_t;
  logic [63:0] rx_data_in, rx_data_out, tx_data, tx_data_out;
  logic        rx_en, rx_valid, tx_en, tx_valid, tx_ready;

  int tests, fails, cyc, last_slip2;
  int slip_cnt [8];
  logic rot_en;

  phy_dq_lane_ctrl dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .train_start (train_start),
    .train_busy  (train_busy),
    .train_done  (train_done),
    .train_fail  (train_fail),
    .lane_locked (lane_locked),
    .bitslip     (bitslip),
    .rx_data_in  (rx_data_in),
    .rx_en       (rx_en),
    .rx_data_out (rx_data_out),
    .rx_valid    (rx_valid),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data_out (tx_data_out),
    .tri_t       (tri_t)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge; sample outputs 1ns later, count slips and model lane-2 bitslip.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    for (int i = 0; i < 8; i++) if (bitslip[i]) slip_cnt[i]++;
    if (bitslip[2]) begin
      if (last_slip2 != 0) check_eq("slip_spacing", 64'(cyc - last_slip2), 64'd4);
      last_slip2 = cyc;
      if (rot_en) rx_data_in[23:16] = {rx_data_in[16], rx_data_in[23:17]};
    end
  endtask

  task automatic clear_slips();
    for (int i = 0; i < 8; i++) slip_cnt[i] = 0;
    last_slip2 = 0;
  endtask

  task automatic pulse_start();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int n = 0; n < max_cycles && train_busy; n++) tick();
    check_eq("busy_timeout", {63'd0, train_busy}, 64'd0);
  endtask

  initial begin
    int others;
    tests = 0; fails = 0; cyc = 0; rot_en = 1'b0;
    clear_slips();
    reset = 1'b1; train_start = 1'b0; rx_en = 1'b0; tx_en = 1'b0; tx_valid = 1'b0;
    tx_data = '0; rx_data_in = {8{8'h1D}};
    repeat (3) tick();
    reset = 1'b0;
    check_eq("rst_tri", tri_t, 64'hFF);
    check_eq("rst_ready", tx_ready, 0);
    check_eq("rst_rxv", rx_valid, 0);
    check_eq("rst_flags", {train_busy, train_done, train_fail}, 0);
    check_eq("rst_locked", lane_locked, 0);
    check_eq("rst_slip", bitslip, 0);
    check_eq("rst_rxd", rx_data_out, 0);
    check_eq("rst_txd", tx_data_out, 0);

    // rx path: 1-cycle latency, hold when rx_en low
    rx_data_in = 64'h0123_4567_89AB_CDEF; rx_en = 1'b1;
    tick();
    check_eq("rx_valid", rx_valid, 1);
    check_eq("rx_data", rx_data_out, 64'h0123_4567_89AB_CDEF);
    rx_en = 1'b0; rx_data_in = 64'hFEDC_BA98_7654_3210;
    tick();
    check_eq("rx_idle_valid", rx_valid, 0);
    check_eq("rx_hold", rx_data_out, 64'h0123_4567_89AB_CDEF);

    // aligned training: lock lands SLIP_WAIT+MATCH_COUNT edges after the start edge
    rx_data_in = {8{8'h1D}}; clear_slips();
    pulse_start();
    check_eq("al_busy", train_busy, 1);
    repeat (6) tick();
    check_eq("al_early_lock", lane_locked, 0);
    check_eq("al_early_done", train_done, 0);
    tick();
    check_eq("al_locked", lane_locked, 64'hFF);
    check_eq("al_done", train_done, 1);
    check_eq("al_busy_fall", train_busy, 0);
    check_eq("al_fail", train_fail, 0);
    others = 0;
    for (int i = 0; i < 8; i++) others += slip_cnt[i];
    check_eq("al_no_slips", 64'(others), 0);

    // lane 2 starts rotated left by 3; each bitslip rotates right by 1
    rx_data_in = {8{8'h1D}}; rx_data_in[23:16] = 8'hE8; rot_en = 1'b1; clear_slips();
    pulse_start();
    wait_idle(100);
    rot_en = 1'b0;
    check_eq("rot_slips2", 64'(slip_cnt[2]), 3);
    others = 0;
    for (int i = 0; i < 8; i++) if (i != 2) others += slip_cnt[i];
    check_eq("rot_other_slips", 64'(others), 0);
    check_eq("rot_locked", lane_locked, 64'hFF);
    check_eq("rot_done", train_done, 1);
    check_eq("rot_fail", train_fail, 0);

    // lane 5 never matches: 2*DATA_WIDTH slips, then fail
    rx_data_in = {8{8'h1D}}; rx_data_in[47:40] = 8'h00; clear_slips();
    pulse_start();
    check_eq("fl_done_clr", train_done, 0);
    wait_idle(200);
    check_eq("fl_slips5", 64'(slip_cnt[5]), 16);
    check_eq("fl_slips0", 64'(slip_cnt[0]), 0);
    check_eq("fl_locked", lane_locked, 64'hDF);
    check_eq("fl_done", train_done, 0);
    check_eq("fl_fail", train_fail, 1);

    // turnaround into TX
    rx_data_in = {8{8'h1D}};
    tx_en = 1'b1;
    tick();
    check_eq("tt_tri", tri_t, 0);
    check_eq("tt_ready0", tx_ready, 0);
    check_eq("tt_pre", tx_data_out, 0);
    tick();
    check_eq("tt_ready1", tx_ready, 0);
    tick();
    check_eq("tt_ready2", tx_ready, 1);
    tx_valid = 1'b1; tx_data = 64'h1111_2222_3333_4444;
    tick();
    check_eq("tx_w1", tx_data_out, 64'h1111_2222_3333_4444);
    tx_data = 64'hA5A5_5A5A_0F0F_F0F0;
    tick();
    check_eq("tx_w2", tx_data_out, 64'hA5A5_5A5A_0F0F_F0F0);
    tx_data = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    check_eq("tx_w3", tx_data_out, 64'hDEAD_BEEF_CAFE_F00D);
    tx_valid = 1'b0;
    pulse_start();
    check_eq("tx_idle_zero", tx_data_out, 0);
    check_eq("tx_start_ignored", train_busy, 0);
    check_eq("tx_still_driving", tri_t, 0);

    // turnaround back to RX
    tx_en = 1'b0; rx_en = 1'b1;
    tick();
    check_eq("tr_tri", tri_t, 64'hFF);
    check_eq("tr_ready", tx_ready, 0);
    check_eq("tr_rxv0", rx_valid, 0);
    tick();
    check_eq("tr_rxv1", rx_valid, 0);
    tick();
    check_eq("tr_rxv2", rx_valid, 0);
    tick();
    check_eq("tr_rxv3", rx_valid, 1);
    rx_en = 1'b0;

    // start and tx_en together: training wins, TX follows once busy falls
    tx_en = 1'b1;
    pulse_start();
    check_eq("cf_busy", train_busy, 1);
    check_eq("cf_tri", tri_t, 64'hFF);
    repeat (6) tick();
    check_eq("cf_tri_mid", tri_t, 64'hFF);
    tick();
    check_eq("cf_done", train_done, 1);
    check_eq("cf_tri_end", tri_t, 64'hFF);
    tick();
    check_eq("cf_tx_start", tri_t, 0);
    repeat (2) tick();
    check_eq("cf_ready", tx_ready, 1);

    // reset held 3 cycles during TX aborts everything
    tx_valid = 1'b1; tx_data = 64'h5555_AAAA_5555_AAAA;
    reset = 1'b1;
    repeat (3) tick();
    check_eq("rtx_tri", tri_t, 64'hFF);
    check_eq("rtx_ready", tx_ready, 0);
    check_eq("rtx_rxv", rx_valid, 0);
    check_eq("rtx_flags", {train_busy, train_done, train_fail}, 0);
    check_eq("rtx_locked", lane_locked, 0);
    check_eq("rtx_txd", tx_data_out, 0);
    reset = 1'b0; tx_en = 1'b0; tx_valid = 1'b0;
    tick();
    check_eq("rtx_after", tri_t, 64'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
